mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl_spi_shifter.sv | 59 +++++
 rtl/mem_ctrl.sv | 97 +++++++++
 tb/tb_mem_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SPI memory controller and its shifter.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic {
        PC  = 1'b0,
        MAR = 1'b1
    } addr_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } mem_ctrl_state_e;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         FRAME_BITS    = 40;

endpackage

// File: rtl/mem_ctrl_spi_shifter.sv
// SPI mode-0 bit engine: shifts a 40-bit frame out MSB first, two clocks per bit,
// and collects the last eight MISO bits of read frames.
module spi_shifter
    import mem_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic                  sample_en,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  spi_miso,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  last,
    output logic [7:0]            rx_data
);

    logic [FRAME_BITS-1:0] out_sr;
    logic [7:0]            in_sr;
    logic                  phase;
    logic [5:0]            bit_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_sr  <= '0;
            in_sr   <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            last    <= 1'b0;
        end else if (load) begin
            out_sr  <= frame;
            in_sr   <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            last    <= 1'b0;
        end else if (shift_en) begin
            if (!phase) begin
                // Rising sclk edge: the data byte occupies frame bits 32..39 of the count.
                phase <= 1'b1;
                if (sample_en && bit_cnt >= 6'd32)
                    in_sr <= {in_sr[6:0], spi_miso};
                last  <= (bit_cnt == 6'd39);
            end else begin
                phase   <= 1'b0;
                out_sr  <= {out_sr[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 6'd1;
                last    <= 1'b0;
            end
        end
    end

    assign spi_sclk = shift_en & phase;
    assign spi_mosi = shift_en & out_sr[FRAME_BITS-1];
    assign rx_data  = in_sr;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: turns read/write requests into single SPI frames to flash (PC)
// or RAM (MAR), and returns read data with a one-cycle done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  addr_sel_e                 addr_sel,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      flash_cs_n,
    output logic                      ram_cs_n
);

    mem_ctrl_state_e       state, state_nxt;
    mem_ctrl_op_e          op_q;
    addr_sel_e             sel_q;
    logic                  accept, legal, load, shift_last;
    logic [FRAME_BITS-1:0] frame;
    logic [23:0]           addr_ext;
    logic [7:0]            wr_byte, rx_data;

    assign accept   = (state == ST_IDLE) && (mem_ctrl_op != MEM_NOP);
    assign legal    = !((mem_ctrl_op == MEM_WRITE) && (addr_sel == PC));
    assign load     = accept && legal;
    assign addr_ext = 24'(addr_in);
    assign wr_byte  = (mem_ctrl_op == MEM_WRITE) ? 8'(data_in) : 8'h00;
    assign frame    = {(mem_ctrl_op == MEM_WRITE) ? SPI_CMD_WRITE : SPI_CMD_READ, addr_ext, wr_byte};

    spi_shifter u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift_en  (state == ST_SHIFT),
        .sample_en (op_q == MEM_READ),
        .frame     (frame),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .last      (shift_last),
        .rx_data   (rx_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= MEM_NOP;
            sel_q    <= PC;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= mem_ctrl_op;
                sel_q <= addr_sel;
            end
            if ((state == ST_SHIFT) && shift_last && (op_q == MEM_READ))
                data_out <= DATA_BUS_WIDTH'(rx_data);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt   = state;
        mem_op_done = 1'b0;
        flash_cs_n  = 1'b1;
        ram_cs_n    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = legal ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                flash_cs_n = (sel_q != PC);
                ram_cs_n   = (sel_q != MAR);
                if (shift_last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                mem_op_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a vector table of SPI transactions against a
// serial memory model, plus hand sequences for held ops, illegal ops and reset abort.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    mem_ctrl_op_e mem_ctrl_op;
    addr_sel_e    addr_sel;
    logic [15:0]  addr_in;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         mem_op_done, spi_sclk, spi_mosi, spi_miso, flash_cs_n, ram_cs_n;

    mem_ctrl #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_ctrl_op (mem_ctrl_op),
        .addr_sel    (addr_sel),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .mem_op_done (mem_op_done),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .flash_cs_n  (flash_cs_n),
        .ram_cs_n    (ram_cs_n)
    );

    always #5 clock = ~clock;

    typedef struct {
        mem_ctrl_op_e op;
        addr_sel_e    sel;
        logic [15:0]  addr;
        logic [7:0]   data;
        logic [7:0]   miso;
        logic [39:0]  frame;
        logic [1:0]   cs;      // {flash, ram}: which chip select must fall once
        logic [7:0]   dout;
        int           lat;     // posedges from the accept edge to the done cycle
        bit           scramble;
    } vec_t;

    typedef struct {
        logic [39:0] frame;
        logic [1:0]  cs;
        logic [7:0]  dout;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    // Serial memory model and bus monitor, all sampled on the falling clock edge.
    logic [7:0]  miso_byte = 8'h00;
    logic [39:0] mosi_frame = '0;
    int          rises = 0, done_count = 0, flash_falls = 0, ram_falls = 0;
    logic        prev_sclk = 1'b0, prev_flash = 1'b1, prev_ram = 1'b1;

    always @(negedge clock) begin
        if (prev_flash && !flash_cs_n) flash_falls++;
        if (prev_ram && !ram_cs_n) ram_falls++;
        if ((prev_flash && prev_ram) && (!flash_cs_n || !ram_cs_n)) mosi_frame = '0;
        if (mem_op_done) done_count++;
        if (!flash_cs_n || !ram_cs_n) begin
            if (!prev_sclk && spi_sclk) begin
                mosi_frame = {mosi_frame[38:0], spi_mosi};
                rises++;
            end
        end else begin
            rises = 0;
        end
        prev_sclk  = spi_sclk;
        prev_flash = flash_cs_n;
        prev_ram   = ram_cs_n;
        spi_miso   = (rises >= 32 && rises < 40) ? miso_byte[39 - rises] : 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        miso_byte   = v.miso;
        mem_ctrl_op = v.op;
        addr_sel    = v.sel;
        addr_in     = v.addr;
        data_in     = v.data;
        e.frame = v.frame;
        e.cs    = v.cs;
        e.dout  = v.dout;
        e.lat   = v.lat;
        sb.push_back(e);
    endtask

    // Waits for done, pops the scoreboard and checks the completed transaction.
    task automatic complete(input string name, input bit hold, input bit scramble);
        int   cyc, base_done, base_ff, base_rf;
        bit   got;
        exp_t e;
        base_done = done_count;
        base_ff   = flash_falls;
        base_rf   = ram_falls;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (scramble && cyc == 20) begin
                addr_in = ~addr_in;
                data_in = ~data_in;
            end
            if (mem_op_done) got = 1'b1;
        end
        check({name, " done_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        check({name, " latency"}, 64'(cyc), 64'(e.lat));
        check({name, " data_out"}, 64'(data_out), 64'(e.dout));
        check({name, " cs_idle_at_done"}, 64'({flash_cs_n, ram_cs_n}), 64'd3);
        check({name, " sclk_mosi_at_done"}, 64'({spi_sclk, spi_mosi}), 64'd0);
        check({name, " flash_falls"}, 64'(flash_falls - base_ff), 64'(e.cs[1]));
        check({name, " ram_falls"}, 64'(ram_falls - base_rf), 64'(e.cs[0]));
        if (e.cs != 2'b00)
            check({name, " mosi_frame"}, 64'(mosi_frame), 64'(e.frame));
        if (!hold) mem_ctrl_op = MEM_NOP;
        @(negedge clock);
        check({name, " done_one_cycle"}, 64'(mem_op_done), 64'd0);
        check({name, " done_count"}, 64'(done_count - base_done), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   base_done;

        vecs[0] = '{MEM_READ,  MAR, 16'h1234, 8'h00, 8'hA5, 40'h03_001234_00, 2'b01, 8'hA5, 81, 1'b0};
        vecs[1] = '{MEM_WRITE, MAR, 16'h00FF, 8'h3C, 8'h00, 40'h02_0000FF_3C, 2'b01, 8'hA5, 81, 1'b0};
        vecs[2] = '{MEM_READ,  PC,  16'hFFFF, 8'h00, 8'h81, 40'h03_00FFFF_00, 2'b10, 8'h81, 81, 1'b0};
        // Illegal: op presented in the cycle before the accept edge, done in the cycle after it.
        vecs[3] = '{MEM_WRITE, PC,  16'h5555, 8'h77, 8'h00, 40'h0,            2'b00, 8'h81, 1,  1'b0};
        vecs[4] = '{MEM_READ,  MAR, 16'h0000, 8'hEE, 8'h00, 40'h03_000000_00, 2'b01, 8'h00, 81, 1'b0};
        vecs[5] = '{MEM_WRITE, MAR, 16'hABCD, 8'hFF, 8'h5A, 40'h02_00ABCD_FF, 2'b01, 8'h00, 81, 1'b1};

        reset       = 1'b1;
        mem_ctrl_op = MEM_NOP;
        addr_sel    = PC;
        addr_in     = '0;
        data_in     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset data_out", 64'(data_out), 64'd0);
        check("reset done", 64'(mem_op_done), 64'd0);
        check("reset sclk_mosi", 64'({spi_sclk, spi_mosi}), 64'd0);
        check("reset cs", 64'({flash_cs_n, ram_cs_n}), 64'd3);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            complete($sformatf("vec%0d", i), 1'b0, vecs[i].scramble);
        end

        // Op held at READ through done: no retrigger in the done cycle, then a clean second frame.
        v = '{MEM_READ, PC, 16'h0100, 8'h00, 8'h3E, 40'h03_000100_00, 2'b10, 8'h3E, 81, 1'b0};
        drive(v);
        complete("held1", 1'b1, 1'b0);
        check("held idle cs", 64'({flash_cs_n, ram_cs_n}), 64'd3);
        drive(v);
        complete("held2", 1'b0, 1'b0);

        // Reset around bit 20 of a read aborts the frame without a done pulse.
        v = '{MEM_READ, MAR, 16'h0042, 8'h00, 8'hC3, 40'h03_000042_00, 2'b01, 8'hC3, 81, 1'b0};
        base_done = done_count;
        drive(v);
        repeat (41) @(negedge clock);
        check("abort frame_active", 64'(ram_cs_n), 64'd0);
        reset       = 1'b1;
        mem_ctrl_op = MEM_NOP;
        @(negedge clock);
        check("abort cs", 64'({flash_cs_n, ram_cs_n}), 64'd3);
        check("abort sclk_mosi", 64'({spi_sclk, spi_mosi}), 64'd0);
        check("abort data_out", 64'(data_out), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("abort no_done", 64'(done_count - base_done), 64'd0);
        void'(sb.pop_front());
        drive(v);
        complete("after_abort", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
